// File: rtl/iob_fp_mul_seq.sv
// Sequential floating-point multiplier.
// Radix-2 shift-add mantissa product, then normalize, round-nearest-even, pack.
module iob_fp_mul_seq #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              done_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              exception_o,
  output logic [DATA_W-1:0] res_o
);

  localparam int MAN_W  = DATA_W - EXP_W;
  localparam int FRAC_W = MAN_W - 1;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int PW     = 2 * MAN_W;
  localparam int XW     = EXP_W + 2;
  localparam int CW     = $clog2(MAN_W + 1);

  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = '0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SPEC = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_NORM = 3'd3;
  localparam logic [2:0] S_RND  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]       a_q, a_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [MAN_W-1:0]        mb_q, mb_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic                    stk_q, stk_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    exc_q, exc_d;

  logic [EXP_W-1:0]        ea, eb;
  logic [FRAC_W-1:0]       fa, fb;
  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                    sgn;
  logic [MAN_W-1:0]        ma;
  logic [MAN_W:0]          add_v, sum;
  logic [MAN_W-1:0]        mant;
  logic                    grd, sticky, rnd;
  logic [MAN_W:0]          mr;
  logic [FRAC_W-1:0]       frac_r;
  logic signed [XW-1:0]    exp_r;

  // Operand field decode and special-value classification
  always_comb begin
    ea     = a_q[DATA_W-2 -: EXP_W];
    eb     = b_q[DATA_W-2 -: EXP_W];
    fa     = a_q[FRAC_W-1:0];
    fb     = b_q[FRAC_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    sgn    = a_q[DATA_W-1] ^ b_q[DATA_W-1];
    ma     = {1'b1, fa};
  end

  // Rounding of the normalized product
  always_comb begin
    mant   = acc_q[PW-2 -: MAN_W];
    grd    = acc_q[PW-2-MAN_W];
    sticky = (|acc_q[PW-3-MAN_W:0]) | stk_q;
    rnd    = grd & (sticky | mant[0]);
    mr     = {1'b0, mant} + {{MAN_W{1'b0}}, rnd};
    exp_r  = mr[MAN_W] ? exp_q + ONE_X : exp_q;
    frac_r = mr[MAN_W] ? '0 : mr[FRAC_W-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mb_d    = mb_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    stk_d   = stk_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    exc_d   = exc_q;
    add_v   = mb_q[0] ? {1'b0, ma} : '0;
    sum     = {1'b0, acc_q[PW-1:MAN_W]} + add_v;
    case (state_q)
      S_SPEC: begin
        sign_d = sgn;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        exc_d  = 1'b0;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
          res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
          exc_d   = 1'b1;
          state_d = S_DONE;
        end else if (a_inf | b_inf) begin
          res_d   = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          state_d = S_DONE;
        end else if (a_zero | b_zero) begin
          res_d   = {sgn, {(DATA_W-1){1'b0}}};
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          acc_d   = '0;
          mb_d    = {1'b1, fb};
          stk_d   = 1'b0;
          exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = {sum, acc_q[MAN_W-1:1]};
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAN_W - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (acc_q[PW-1]) begin
          acc_d = acc_q >> 1;
          stk_d = acc_q[0];
          exp_d = exp_q + ONE_X;
        end
        state_d = S_RND;
      end
      S_RND: begin
        if (exp_r >= EMAX_X) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_r <= ZERO_X) begin
          res_d = {sign_q, {(DATA_W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start_i) begin
      a_d     = op_a_i;
      b_d     = op_b_i;
      state_d = S_SPEC;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mb_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      stk_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mb_q    <= mb_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      stk_q   <= stk_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      exc_q   <= exc_d;
    end
  end

  assign done_o      = (state_q == S_DONE);
  assign res_o       = res_q;
  assign overflow_o  = ovf_q & done_o;
  assign underflow_o = unf_q & done_o;
  assign exception_o = exc_q & done_o;

endmodule
